// File: rtl/param_memory.sv
// Single-port parameter store with programmable wait states and a zero-fill sequence.
// Accesses are latched in IDLE, delayed WAIT_CYCLES edges, then executed in one ACCESS edge.
//   state    | meaning
//   S_IDLE   | ready; samples init (priority) and req
//   S_WAIT   | counting down wait states for the latched access
//   S_ACCESS | performs latched read or write, ack follows
//   S_INIT   | writes zero to one address per edge, 0 .. DEPTH-1
module param_memory #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              init,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              init_done
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_INIT
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
    logic              latch_en;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem [DEPTH];

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        init_cnt_nxt = init_cnt;
        latch_en     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_q;
        mem_din      = wdata_q;
        case (state)
            S_IDLE: begin
                if (init) begin
                    state_nxt    = S_INIT;
                    init_cnt_nxt = '0;
                end else if (req) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACCESS;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt_nxt == 4'd0) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_we    = we_q;
                state_nxt = S_IDLE;
            end
            S_INIT: begin
                mem_we   = 1'b1;
                mem_addr = init_cnt;
                mem_din  = '0;
                // counter parks at the last address rather than wrapping
                if (init_cnt == LAST_ADDR) begin
                    state_nxt = S_IDLE;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            init_cnt  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            ack       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            init_cnt  <= init_cnt_nxt;
            ack       <= (state == S_ACCESS);
            init_done <= (state == S_INIT) && (init_cnt == LAST_ADDR);
            if (latch_en) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if ((state == S_ACCESS) && !we_q) begin
                rdata <= mem[addr_q];
            end
        end
    end

    // storage is deliberately outside the reset domain so contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

endmodule
